// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder
//   PHY-side Clause 22 MDIO management responder. Decodes management frames
//   on mdc/mdio_in (sampled on MDC rising edges), serves reads from a 32x16
//   register file by driving mdio_out/mdio_oen on MDC falling edges, and
//   commits writes with a one-cycle wr_strobe.
// Ports:
//   clk_clk, reset_reset_n      system clock, synchronous active-low reset
//   mdc, mdio_in, link_up       asynchronous inputs (2-FF synchronized)
//   mdio_out, mdio_oen          MDIO drive data / enable (oen=1 releases bus)
//   ctrl_reg                    register 0 contents
//   wr_strobe, wr_addr, wr_data committed-write pulse and its address/data
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2,
    parameter logic [15:0] CTRL_DEFAULT = 16'h1140,
    parameter logic [15:0] STATUS_BASE  = 16'h7949,
    parameter int          PREAMBLE_MIN = 32
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        link_up,
    output logic [15:0] ctrl_reg,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
    } state_t;

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

    logic [2:0]  mdc_q;
    logic [1:0]  mdio_q, link_q;
    logic        rise_q, fall_q;
    state_t      state_q, state_d;
    logic [5:0]  pre_cnt_q;
    logic [4:0]  bit_cnt_q;
    logic        op_q, rd_q;
    logic [4:0]  phyad_q, regad_q;
    logic [15:0] sh_q;
    logic [15:0] rf_q [32];
    logic        mdio_out_q, mdio_oen_q, wr_strobe_q;
    logic [4:0]  wr_addr_q;
    logic [15:0] wr_data_q;
    logic        bit_w;
    logic [15:0] rd_val, wdat;

    assign bit_w = mdio_q[1];
    // Write data is complete only with the D0 bit sampled on this rise.
    assign wdat  = {sh_q[14:0], bit_w};

    // Synchronizers carry no reset; rise/fall events are registered so they
    // appear three cycles after the pin edge.
    always_ff @(posedge clk_clk) begin
        mdc_q  <= {mdc_q[1:0], mdc};
        mdio_q <= {mdio_q[0], mdio_in};
        link_q <= {link_q[0], link_up};
    end

    always_comb begin
        unique case (regad_q)
            5'd1:    rd_val = {STATUS_BASE[15:3], link_q[1], STATUS_BASE[1:0]};
            5'd2:    rd_val = PHY_ID1;
            5'd3:    rd_val = PHY_ID2;
            default: rd_val = rf_q[regad_q];
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (rise_q) begin
            unique case (state_q)
                S_IDLE:  if (!bit_w && pre_cnt_q >= PRE_MIN) state_d = S_ST1;
                S_ST1:   state_d = bit_w ? S_OP : S_IDLE;
                S_OP:    if (bit_cnt_q == 5'd0)
                             state_d = (op_q != bit_w) ? S_PHYAD : S_IDLE;
                S_PHYAD: if (bit_cnt_q == 5'd0) state_d = S_REGAD;
                S_REGAD: if (bit_cnt_q == 5'd0)
                             state_d = (phyad_q == PHY_ADDR) ? S_TA : S_SKIP;
                S_TA:    if (bit_cnt_q == 5'd0) state_d = S_DATA;
                S_DATA:  if (bit_cnt_q == 5'd0) state_d = S_IDLE;
                S_SKIP:  if (bit_cnt_q == 5'd0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            state_q     <= S_IDLE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            op_q        <= 1'b0;
            rd_q        <= 1'b0;
            phyad_q     <= '0;
            regad_q     <= '0;
            sh_q        <= '0;
            mdio_out_q  <= 1'b1;
            mdio_oen_q  <= 1'b1;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= (i == 0) ? CTRL_DEFAULT : '0;
        end else begin
            rise_q      <= mdc_q[1] & ~mdc_q[2];
            fall_q      <= ~mdc_q[1] & mdc_q[2];
            state_q     <= state_d;
            wr_strobe_q <= 1'b0;

            if (rise_q) begin
                // Preamble run length: only ones seen in IDLE accumulate.
                if (state_q == S_IDLE && bit_w)
                    pre_cnt_q <= (pre_cnt_q == 6'd63) ? pre_cnt_q : pre_cnt_q + 6'd1;
                else
                    pre_cnt_q <= '0;

                if (state_d != state_q) begin
                    unique case (state_d)
                        S_OP:    bit_cnt_q <= 5'd1;
                        S_PHYAD: bit_cnt_q <= 5'd4;
                        S_REGAD: bit_cnt_q <= 5'd4;
                        S_TA:    bit_cnt_q <= 5'd1;
                        S_DATA:  bit_cnt_q <= 5'd15;
                        S_SKIP:  bit_cnt_q <= 5'd17;
                        default: bit_cnt_q <= 5'd0;
                    endcase
                end else if (state_q != S_IDLE) begin
                    bit_cnt_q <= bit_cnt_q - 5'd1;
                end

                unique case (state_q)
                    S_OP: begin
                        if (bit_cnt_q == 5'd1) op_q <= bit_w;
                        else                   rd_q <= op_q & ~bit_w;
                    end
                    S_PHYAD: phyad_q <= {phyad_q[3:0], bit_w};
                    S_REGAD: regad_q <= {regad_q[3:0], bit_w};
                    S_TA:    if (bit_cnt_q == 5'd1 && rd_q) sh_q <= rd_val;
                    S_DATA: begin
                        if (!rd_q) begin
                            sh_q <= wdat;
                            if (bit_cnt_q == 5'd0) begin
                                if (regad_q == 5'd0) begin
                                    wr_strobe_q <= 1'b1;
                                    wr_addr_q   <= regad_q;
                                    wr_data_q   <= wdat;
                                    // Bit 15 is a self-clearing soft reset.
                                    if (wdat[15])
                                        for (int i = 0; i < 32; i++)
                                            rf_q[i] <= (i == 0) ? CTRL_DEFAULT : '0;
                                    else
                                        rf_q[0] <= wdat;
                                end else if (regad_q > 5'd3) begin
                                    wr_strobe_q     <= 1'b1;
                                    wr_addr_q       <= regad_q;
                                    wr_data_q       <= wdat;
                                    rf_q[regad_q]   <= wdat;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // Drive side: TA2 zero, then D15..D0, release on the fall after D0.
            if (fall_q) begin
                if (rd_q && state_q == S_TA && bit_cnt_q == 5'd0) begin
                    mdio_oen_q <= 1'b0;
                    mdio_out_q <= 1'b0;
                end else if (rd_q && state_q == S_DATA) begin
                    mdio_oen_q <= 1'b0;
                    mdio_out_q <= sh_q[15];
                    sh_q       <= {sh_q[14:0], 1'b0};
                end else begin
                    mdio_oen_q <= 1'b1;
                    mdio_out_q <= 1'b1;
                end
            end
        end
    end

    assign mdio_out  = mdio_out_q;
    assign mdio_oen  = mdio_oen_q;
    assign ctrl_reg  = rf_q[0];
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder
//   Drives Clause 22 frames as an MDIO master (16 clk per MDC period) and
//   compares the responder against a register-level model of the PHY.
module tb_mdio_phy_responder;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio_in = 1'b1;
    logic        link_up = 1'b0;
    logic        mdio_out, mdio_oen, wr_strobe;
    logic [15:0] ctrl_reg, wr_data;
    logic [4:0]  wr_addr;

    mdio_phy_responder dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .mdc(mdc),
        .mdio_in(mdio_in), .mdio_out(mdio_out), .mdio_oen(mdio_oen),
        .link_up(link_up), .ctrl_reg(ctrl_reg), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk_clk = ~clk_clk;

    int n_chk = 0;
    int n_fail = 0;

    // Bus monitor: strobe-high cycles and drive cycles only ever count up.
    int          stb_cyc = 0;
    int          oen_cyc = 0;
    logic [4:0]  cap_addr = '0;
    logic [15:0] cap_data = '0;
    always @(negedge clk_clk) begin
        if (wr_strobe) begin
            stb_cyc++;
            cap_addr = wr_addr;
            cap_data = wr_data;
        end
        if (!mdio_oen) oen_cyc++;
    end

    // Reference PHY register model.
    logic [15:0] m_rf [32];
    logic        m_link = 1'b0;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_rf[0] = 16'h1140;
    endtask

    function automatic logic [15:0] m_read(input logic [4:0] a);
        case (a)
            5'd1:    return m_link ? 16'h794D : 16'h7949;
            5'd2:    return 16'h0141;
            5'd3:    return 16'h0CC2;
            default: return m_rf[a];
        endcase
    endfunction

    task automatic m_write(input logic [4:0] a, input logic [15:0] d);
        if (a == 5'd0) begin
            if (d[15]) m_reset();
            else       m_rf[0] = d;
        end else if (a > 5'd3) begin
            m_rf[a] = d;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One MDC period: data changes with the falling edge; the bus is sampled
    // at the end of the low phase, just before the rising edge.
    task automatic mdc_bit(input logic b, output logic s_oen, output logic s_out);
        mdc = 1'b0;
        mdio_in = b;
        repeat (8) @(negedge clk_clk);
        s_oen = mdio_oen;
        s_out = mdio_out;
        mdc = 1'b1;
        repeat (8) @(negedge clk_clk);
    endtask

    // Frame layout: pre ones, 01, op, phyad, regad, TA, 16 data, one trailing 0.
    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd, input int abort_at,
                         output int low, output logic [15:0] rd, output logic ta_ok);
        logic q[$];
        logic so, sd;
        for (int i = 0; i < pre; i++) q.push_back(1'b1);
        q.push_back(1'b0); q.push_back(1'b1);
        q.push_back(op[1]); q.push_back(op[0]);
        for (int i = 4; i >= 0; i--) q.push_back(pa[i]);
        for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
        q.push_back(1'b1); q.push_back(op == 2'b01 ? 1'b0 : 1'b1);
        for (int i = 15; i >= 0; i--) q.push_back(op == 2'b01 ? wd[i] : 1'b1);
        q.push_back(1'b0);
        low = 0; rd = '0; ta_ok = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            if (k == abort_at) begin
                mdc = 1'b0;
                mdio_in = q[k];
                repeat (8) @(negedge clk_clk);
                chk("abort_pre_drive", mdio_oen, 1'b0);
                reset_reset_n = 1'b0;
                @(negedge clk_clk);
                chk("abort_oen", mdio_oen, 1'b1);
                chk("abort_out", mdio_out, 1'b1);
                repeat (2) @(negedge clk_clk);
                reset_reset_n = 1'b1;
                m_reset();
                break;
            end
            mdc_bit(q[k], so, sd);
            if (!so) low++;
            if (k == pre + 15) ta_ok = !so && !sd;
            if (k >= pre + 16 && k <= pre + 31) rd = {rd[14:0], sd};
        end
    endtask

    task automatic txn(input int pre, input logic [1:0] op, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd);
        int low, s0, c0;
        logic [15:0] rd, exp_rd;
        logic ta_ok, valid;
        valid  = (pre >= 32) && (op == 2'b10 || op == 2'b01) && (pa == 5'd0);
        exp_rd = m_read(ra);
        s0 = stb_cyc; c0 = oen_cyc;
        frame(pre, op, pa, ra, wd, -1, low, rd, ta_ok);
        if (valid && op == 2'b10) begin
            chk("rd_drive_periods", low, 17);
            chk("rd_drive_cycles", oen_cyc - c0, 272);
            chk("rd_ta2_zero", ta_ok, 1'b1);
            chk("rd_data", rd, exp_rd);
        end else begin
            chk("no_drive", oen_cyc - c0, 0);
        end
        if (valid && op == 2'b01 && (ra == 5'd0 || ra > 5'd3)) begin
            m_write(ra, wd);
            chk("wr_strobe_pulses", stb_cyc - s0, 1);
            chk("wr_addr", cap_addr, ra);
            chk("wr_data", cap_data, wd);
        end else begin
            chk("no_strobe", stb_cyc - s0, 0);
        end
        chk("ctrl_reg", ctrl_reg, m_rf[0]);
    endtask

    initial begin
        int low, c0;
        logic [15:0] rd;
        logic ta_ok, so, sd;
        int pre;
        logic [1:0] op;
        logic [4:0] pa, ra;
        logic [15:0] wd;

        m_reset();
        repeat (4) @(negedge clk_clk);
        chk("rst_oen", mdio_oen, 1'b1);
        chk("rst_out", mdio_out, 1'b1);
        chk("rst_ctrl", ctrl_reg, 16'h1140);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_waddr", wr_addr, 5'd0);
        chk("rst_wdata", wr_data, 16'h0);
        reset_reset_n = 1'b1;
        repeat (2) @(negedge clk_clk);

        c0 = oen_cyc;
        for (int i = 0; i < 100; i++) mdc_bit(1'b1, so, sd);
        chk("idle_no_drive", oen_cyc - c0, 0);

        txn(32, 2'b10, 5'd0, 5'd2, 16'h0);
        txn(32, 2'b01, 5'd0, 5'd5, 16'hABCD);
        txn(32, 2'b10, 5'd0, 5'd5, 16'h0);
        txn(32, 2'b10, 5'd3, 5'd2, 16'h0);
        txn(31, 2'b10, 5'd0, 5'd2, 16'h0);
        txn(32, 2'b11, 5'd0, 5'd2, 16'h0);
        txn(32, 2'b10, 5'd0, 5'd3, 16'h0);
        txn(32, 2'b01, 5'd0, 5'd2, 16'h1234);

        link_up = 1'b1; m_link = 1'b1;
        txn(32, 2'b10, 5'd0, 5'd1, 16'h0);
        txn(32, 2'b01, 5'd0, 5'd0, 16'h8000);
        txn(32, 2'b10, 5'd0, 5'd5, 16'h0);
        txn(32, 2'b10, 5'd0, 5'd0, 16'h0);

        // Reset during D8 of a read, then a clean read.
        txn(32, 2'b01, 5'd0, 5'd7, 16'h5A5A);
        frame(32, 2'b10, 5'd0, 5'd2, 16'h0, 32 + 16 + 7, low, rd, ta_ok);
        chk("post_abort_ctrl", ctrl_reg, 16'h1140);
        txn(32, 2'b10, 5'd0, 5'd2, 16'h0);
        txn(32, 2'b10, 5'd0, 5'd7, 16'h0);

        for (int n = 0; n < 30; n++) begin
            m_link  = 1'($urandom_range(0, 1));
            link_up = m_link;
            case ($urandom_range(0, 7))
                0:       op = 2'b00;
                1:       op = 2'b11;
                2, 3, 4: op = 2'b10;
                default: op = 2'b01;
            endcase
            pre = ($urandom_range(0, 7) == 0) ? 31 : 32 + $urandom_range(0, 3);
            pa  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            ra  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                              : 5'($urandom_range(0, 31));
            wd  = 16'($urandom);
            if (ra == 5'd0 && $urandom_range(0, 1) == 1) wd[15] = 1'b0;
            txn(pre, op, pa, ra, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdio_phy_responder.md
# mdio_phy_responder

PHY-side IEEE 802.3 Clause 22 MDIO management responder: the slave end of the MDC/MDIO interface driven by the TSE MAC's management master. It decodes management frames on `mdc`/`mdio_in`, serves reads from a 32×16 PHY register file over `mdio_out`/`mdio_oen`, and commits writes. It sits on the system clock next to the MAC conduit and gives simulation and loopback builds an emulated PHY when no external PHY is attached.

## Interface
- `PHY_ADDR`, 5'd0: PHY address this block answers to.
- `PHY_ID1`, 16'h0141: read-only value of register 2.
- `PHY_ID2`, 16'h0CC2: read-only value of register 3.
- `CTRL_DEFAULT`, 16'h1140: reset value of register 0.
- `STATUS_BASE`, 16'h7949: register 1 value; bit 2 is replaced by `link_up`.
- `PREAMBLE_MIN`, 32: number of consecutive ones required before ST.
- `clk_clk` in 1: system clock. Single clock domain.
- `reset_reset_n` in 1: reset, synchronous, active-low.
- `mdc` in 1: management clock from the MAC, asynchronous to `clk_clk`.
- `mdio_in` in 1: MDIO pin value, asynchronous.
- `mdio_out` out 1: data driven onto MDIO when enabled.
- `mdio_oen` out 1: output enable, 1 = released (high-Z), 0 = drive `mdio_out`.
- `link_up` in 1: asynchronous link indication, reflected in register 1 bit 2.
- `ctrl_reg` out 16: current register 0 contents.
- `wr_strobe` out 1: one-cycle pulse per committed write.
- `wr_addr` out 5: register address of the last committed write.
- `wr_data` out 16: data of the last committed write.

## Operation
- Input conditioning:
  - `mdc`, `mdio_in` and `link_up` each pass through a 2-FF synchronizer.
  - A third `mdc` flop detects edges and produces a rise event and a fall event, each one cycle wide.
- Bits are sampled on rise events and outputs change on fall events. MSB is first on the wire.
- FSM states, all transitions on rise events:
  - IDLE/PRE: count consecutive ones, saturating at 63; a 1 increments the count.
    - 0 with count ≥ PREAMBLE_MIN → ST1.
    - 0 with count < PREAMBLE_MIN → count cleared, stay.
  - ST1: 1 → OP; 0 → IDLE (count cleared).
  - OP: 2 bits. 10 = read, 01 = write; 00 or 11 → IDLE.
  - PHYAD: 5 bits.
  - REGAD: 5 bits. At the end, compare PHYAD with PHY_ADDR: mismatch → SKIP, match → TA.
  - TA: 2 bits. A read snapshots the addressed register into a shift register on the first TA rise. A write ignores the TA bit values.
  - DATA: 16 bits. A read shifts out; a write shifts in. After bit 0 → IDLE with count cleared.
  - SKIP: consume 18 bits (TA + data) with the bus released, then → IDLE.
- Read drive on fall events:
  - The fall after the TA1 rise sets `mdio_oen`=0, `mdio_out`=0 (TA2).
  - Each following fall drives the next data bit, D15 first.
  - The fall after the D0 rise sets `mdio_oen`=1, `mdio_out`=1.
  - Total drive time is 17 MDC periods.
- Register map:
  - 0: RW, value CTRL_DEFAULT.
  - 1: RO, STATUS_BASE with bit 2 = synchronized `link_up`.
  - 2: RO, PHY_ID1.
  - 3: RO, PHY_ID2.
  - 4–31: RW, reset 0.
  - Writes to 1–3 are dropped and produce no `wr_strobe`.
- Write commit: on the D0 rise the register is updated in the same cycle and `wr_strobe`/`wr_addr`/`wr_data` are registered. `wr_strobe` is high the next cycle only.
- Soft reset: a write with bit 15 = 1 to register 0 returns all RW registers to their defaults (register 0 becomes CTRL_DEFAULT, so bit 15 reads 0). `wr_strobe` still pulses with the written data.

## Timing
- Reset values, applied the cycle after `reset_reset_n` is sampled low:
  - `mdio_oen`=1, `mdio_out`=1, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0.
  - `ctrl_reg`=CTRL_DEFAULT, registers at defaults.
  - FSM in IDLE with count 0.
- Reset mid-frame aborts the frame and releases the bus the next cycle. The frame in progress is not answered.
- Event latency: an rise/fall event is asserted 3 `clk_clk` cycles after the `mdc` pin edge. `mdio_out`/`mdio_oen` change 1 cycle after the fall event.
- Requirement: each MDC high or low phase is ≥ 6 `clk_clk` cycles. Behaviour below that is undefined.
- `ctrl_reg` updates in the cycle the write commits.
- Read data is the snapshot taken at TA1. A concurrent `link_up` change affects only the next read.
- Back-to-back frames:
  - A new preamble may start immediately after D0.
  - A frame that starts with no idle gap is still decoded, because the count is rebuilt from the preamble.

## Test plan
- Reset → `mdio_oen`=1, `mdio_out`=1, `ctrl_reg`=16'h1140, `wr_strobe`=0; no drive over 100 idle MDC cycles.
- 32 ones, read PHYAD 0 REGAD 2 → `mdio_oen`=0 for exactly 17 MDC periods; wire carries 0, then 16'h0141 MSB first; released afterwards.
- Write 16'hABCD to register 5 → a single `wr_strobe` pulse, `wr_addr`=5, `wr_data`=16'hABCD; a subsequent read of register 5 returns 16'hABCD.
- Read with PHYAD 3, then a 31-one preamble frame, then OP=11 → `mdio_oen` stays 1 throughout and no strobe; the next valid read of register 3 returns 16'h0CC2.
- With `link_up`=1, read register 1 → 16'h794D. Write 16'h8000 to register 0 → `ctrl_reg`=16'h1140, register 5 reads 0, register 0 reads 16'h1140.
- Assert `reset_reset_n` low during D8 of a read → `mdio_oen`=1 the next cycle; a subsequent full read succeeds.
